snake_world_map: RTL and testbench

- Board-state store for the snake game, 15x15 cells, 2-bit cell code per cell.
- Sits directly upstream of the VGA pixel controller: it takes that controller's cell coordinates and returns the cell code it colours.
- Game logic writes cells through a valid/ready command port; each write returns the cell's previous code for collision/food detection.
- Keeps live counts of snake and food cells.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_map_sweep.sv | 54 +++++
 rtl/snake_world_map.sv | 169 ++++++++++++++++
 tb/tb_snake_world_map.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake board-state store: cell codes, command
// encodings, default grid size and the map controller state type.
package snake_pkg;

  localparam int unsigned GRID_W_DEFAULT = 15;
  localparam int unsigned GRID_H_DEFAULT = 15;

  localparam logic [1:0] CELL_WORLD = 2'b00;
  localparam logic [1:0] CELL_FOOD  = 2'b01;
  localparam logic [1:0] CELL_SNAKE = 2'b10;
  localparam logic [1:0] CELL_RSVD  = 2'b11;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  // StClear is the reset state, so it takes the all-zero encoding.
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StIdle  = 1'b1
  } map_state_e;

endpackage

// File: rtl/snake_map_sweep.sv
// Raster-order x/y cell counter used to walk every board cell once.
// start_i returns the counter to (0,0); en_i advances it one cell.
module snake_map_sweep #(
  parameter int unsigned GRID_W = 15,
  parameter int unsigned GRID_H = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       en_i,
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic       last_o
);

  localparam logic [3:0] LastX = 4'(GRID_W - 1);
  localparam logic [3:0] LastY = 4'(GRID_H - 1);

  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;

  // Next position: wrap x at the row end, wrap y after the final cell.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start_i) begin
      x_d = 4'd0;
      y_d = 4'd0;
    end else if (en_i) begin
      if (x_q == LastX) begin
        x_d = 4'd0;
        y_d = (y_q == LastY) ? 4'd0 : y_q + 4'd1;
      end else begin
        x_d = x_q + 4'd1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= 4'd0;
      y_q <= 4'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == LastX) && (y_q == LastY);

endmodule

// File: rtl/snake_world_map.sv
// Board-state store for the snake game. Serves zero-latency cell reads to the
// VGA pixel controller, accepts cell writes/clears from game logic, returns the
// overwritten code for collision/food detection, and tracks snake/food counts.
module snake_world_map
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEFAULT,
  parameter int unsigned GRID_H = GRID_H_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  input  logic [1:0] cmd_code,
  output logic       done,
  output logic [1:0] prev_code,
  output logic       err,
  output logic [7:0] snake_count,
  output logic [7:0] food_count
);

  localparam int unsigned NumCells  = GRID_W * GRID_H;
  localparam logic [3:0]  LastX     = 4'(GRID_W - 1);
  localparam logic [3:0]  LastY     = 4'(GRID_H - 1);
  localparam logic [7:0]  RowStride = 8'(GRID_W);

  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return 8'(y) * RowStride + 8'(x);
  endfunction

  map_state_e  state_q;
  logic [1:0]  cells_q [NumCells];
  logic        done_q;
  logic [1:0]  prev_code_q;
  logic        err_q;
  logic        clear_pend_q;
  logic [7:0]  snake_count_q, snake_count_d;
  logic [7:0]  food_count_q, food_count_d;

  logic [3:0]  sweep_x, sweep_y;
  logic        sweep_last;
  logic        accept;
  logic        clear_start;
  logic        cmd_in_range;
  logic [7:0]  cmd_idx;
  logic [1:0]  old_code;
  logic        do_write;
  logic        rd_in_range;
  logic [7:0]  rd_idx;

  assign cmd_ready   = (state_q == StIdle);
  assign accept      = cmd_valid & cmd_ready;
  assign clear_start = accept & (cmd_op == OP_CLEAR);

  // Out-of-range indices are clamped to 0 so the array is never indexed past its end.
  assign cmd_in_range = (cmd_x <= LastX) && (cmd_y <= LastY);
  assign cmd_idx      = cmd_in_range ? cell_idx(cmd_x, cmd_y) : 8'd0;
  assign old_code     = cells_q[cmd_idx];
  assign do_write     = accept & (cmd_op == OP_WRITE) & cmd_in_range;

  assign rd_in_range = (rd_x <= LastX) && (rd_y <= LastY);
  assign rd_idx      = rd_in_range ? cell_idx(rd_x, rd_y) : 8'd0;
  assign rd_data     = (state_q == StIdle && rd_in_range) ? cells_q[rd_idx] : CELL_WORLD;

  snake_map_sweep #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .start_i (clear_start),
    .en_i    (state_q == StClear),
    .x_o     (sweep_x),
    .y_o     (sweep_y),
    .last_o  (sweep_last)
  );

  // Cell array: unreset storage, cleared only by the sweep.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      cells_q[cell_idx(sweep_x, sweep_y)] <= CELL_WORLD;
    end else if (do_write) begin
      cells_q[cmd_idx] <= cmd_code;
    end
  end

  // Count adjustment for a write: retire the old code, credit the new one.
  always_comb begin
    snake_count_d = snake_count_q;
    food_count_d  = food_count_q;
    if (do_write) begin
      if (old_code == CELL_SNAKE) begin
        snake_count_d = snake_count_d - 8'd1;
      end else if (old_code == CELL_FOOD) begin
        food_count_d = food_count_d - 8'd1;
      end
      if (cmd_code == CELL_SNAKE) begin
        snake_count_d = snake_count_d + 8'd1;
      end else if (cmd_code == CELL_FOOD) begin
        food_count_d = food_count_d + 8'd1;
      end
    end
  end

  // Controller FSM with registered completion outputs and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StClear;
      done_q        <= 1'b0;
      prev_code_q   <= CELL_WORLD;
      err_q         <= 1'b0;
      clear_pend_q  <= 1'b0;
      snake_count_q <= 8'd0;
      food_count_q  <= 8'd0;
    end else begin
      done_q      <= 1'b0;
      prev_code_q <= CELL_WORLD;
      err_q       <= 1'b0;
      unique case (state_q)
        StClear: begin
          if (sweep_last) begin
            state_q       <= StIdle;
            snake_count_q <= 8'd0;
            food_count_q  <= 8'd0;
            // Only a commanded clear reports completion; the reset sweep is silent.
            done_q        <= clear_pend_q;
            clear_pend_q  <= 1'b0;
          end
        end
        StIdle: begin
          snake_count_q <= snake_count_d;
          food_count_q  <= food_count_d;
          if (accept) begin
            unique case (cmd_op)
              OP_CLEAR: begin
                state_q      <= StClear;
                clear_pend_q <= 1'b1;
              end
              OP_WRITE: begin
                done_q      <= 1'b1;
                err_q       <= ~cmd_in_range;
                prev_code_q <= cmd_in_range ? old_code : CELL_WORLD;
              end
              default: begin
                done_q <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign prev_code   = prev_code_q;
  assign err         = err_q;
  assign snake_count = snake_count_q;
  assign food_count  = food_count_q;

endmodule

// File: tb/tb_snake_world_map.sv
// Directed self-checking bench for snake_world_map.
module tb_snake_world_map;

  logic       clk;
  logic       reset;
  logic [3:0] rd_x, rd_y;
  logic [1:0] rd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_x, cmd_y;
  logic [1:0] cmd_code;
  logic       done;
  logic [1:0] prev_code;
  logic       err;
  logic [7:0] snake_count;
  logic [7:0] food_count;

  int n_checks = 0;
  int n_pass   = 0;

  snake_world_map dut (
    .clk         (clk),
    .reset       (reset),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_data     (rd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_code    (cmd_code),
    .done        (done),
    .prev_code   (prev_code),
    .err         (err),
    .snake_count (snake_count),
    .food_count  (food_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input logic [3:0] x, input logic [3:0] y, output logic [1:0] d);
    rd_x = x;
    rd_y = y;
    #1;
    d = rd_data;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                           input logic [1:0] code);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_code  = code;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  // Counts clock edges until cmd_ready rises (bounded), plus done pulses and
  // non-blank reads seen while ready was low.
  task automatic wait_ready(output int cycles, output int dones, output int blanks);
    cycles = 0;
    dones  = 0;
    blanks = 0;
    while (!cmd_ready && cycles < 400) begin
      tick();
      cycles++;
      if (!cmd_ready) begin
        if (done) dones++;
        if (rd_data != 2'b00) blanks++;
      end
    end
  endtask

  int         cyc, dn, bl, bad;
  logic [1:0] d;
  logic [1:0] exp_d;
  logic [3:0] fx [5];
  logic [3:0] fy [5];

  initial begin
    fx = '{4'd0, 4'd14, 4'd1, 4'd2, 4'd0};
    fy = '{4'd0, 4'd14, 4'd0, 4'd0, 4'd1};
    reset = 1'b1;
    rd_x = 4'd0;
    rd_y = 4'd0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_x = 4'd0;
    cmd_y = 4'd0;
    cmd_code = 2'b00;
    repeat (3) tick();

    // Reset state
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_prev", prev_code, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_snake", snake_count, 0);
    check_eq("rst_food", food_count, 0);

    // Reset-initiated sweep
    rd_x = 4'd14;
    rd_y = 4'd14;
    reset = 1'b0;
    wait_ready(cyc, dn, bl);
    check_eq("init_sweep_cycles", cyc, 225);
    check_eq("init_sweep_done", dn, 0);
    check_eq("init_sweep_blank", bl, 0);
    check_eq("init_ready_done", done, 0);
    read_cell(4'd0, 4'd0, d);
    check_eq("init_rd_0_0", d, 0);
    read_cell(4'd14, 4'd14, d);
    check_eq("init_rd_14_14", d, 0);
    check_eq("init_snake", snake_count, 0);
    check_eq("init_food", food_count, 0);

    // Back-to-back writes to (3,4)
    drive_cmd(2'b01, 4'd3, 4'd4, 2'b10);
    tick();
    check_eq("w1_done", done, 1);
    check_eq("w1_prev", prev_code, 0);
    check_eq("w1_err", err, 0);
    check_eq("w1_snake", snake_count, 1);
    check_eq("w1_food", food_count, 0);
    check_eq("w1_ready", cmd_ready, 1);
    drive_cmd(2'b01, 4'd3, 4'd4, 2'b01);
    tick();
    check_eq("w2_done", done, 1);
    check_eq("w2_prev", prev_code, 2);
    check_eq("w2_snake", snake_count, 0);
    check_eq("w2_food", food_count, 1);
    idle_cmd();
    tick();
    check_eq("w_idle_done", done, 0);
    read_cell(4'd3, 4'd4, d);
    check_eq("w_rd_3_4", d, 1);

    // Out-of-range write
    drive_cmd(2'b01, 4'd15, 4'd2, 2'b10);
    tick();
    idle_cmd();
    check_eq("oor_done", done, 1);
    check_eq("oor_err", err, 1);
    check_eq("oor_prev", prev_code, 0);
    check_eq("oor_snake", snake_count, 0);
    check_eq("oor_food", food_count, 1);
    read_cell(4'd15, 4'd2, d);
    check_eq("oor_rd_15_2", d, 0);

    // Same-code rewrite leaves counts alone
    drive_cmd(2'b01, 4'd3, 4'd4, 2'b01);
    tick();
    idle_cmd();
    check_eq("same_prev", prev_code, 1);
    check_eq("same_food", food_count, 1);
    check_eq("same_snake", snake_count, 0);

    // Op 11 behaves as NOP
    drive_cmd(2'b11, 4'd3, 4'd4, 2'b10);
    tick();
    idle_cmd();
    check_eq("op11_done", done, 1);
    check_eq("op11_err", err, 0);
    check_eq("op11_prev", prev_code, 0);
    check_eq("op11_snake", snake_count, 0);
    read_cell(4'd3, 4'd4, d);
    check_eq("op11_rd_3_4", d, 1);

    // Reserved code is stored but not counted
    drive_cmd(2'b01, 4'd9, 4'd9, 2'b11);
    tick();
    idle_cmd();
    check_eq("rsvd_snake", snake_count, 0);
    check_eq("rsvd_food", food_count, 1);
    read_cell(4'd9, 4'd9, d);
    check_eq("rsvd_rd_9_9", d, 3);

    // Fill 5 snake cells, then CLEAR
    for (int i = 0; i < 5; i++) begin
      drive_cmd(2'b01, fx[i], fy[i], 2'b10);
      tick();
    end
    idle_cmd();
    check_eq("fill_snake", snake_count, 5);
    check_eq("fill_food", food_count, 1);
    rd_x = 4'd0;
    rd_y = 4'd0;
    drive_cmd(2'b10, 4'd0, 4'd0, 2'b00);
    tick();
    idle_cmd();
    check_eq("clr_done_early", done, 0);
    wait_ready(cyc, dn, bl);
    check_eq("clr_cycles", cyc, 225);
    check_eq("clr_done_during", dn, 0);
    check_eq("clr_blank", bl, 0);
    check_eq("clr_done", done, 1);
    check_eq("clr_err", err, 0);
    check_eq("clr_prev", prev_code, 0);
    check_eq("clr_snake", snake_count, 0);
    check_eq("clr_food", food_count, 0);
    tick();
    check_eq("clr_done_once", done, 0);
    bad = 0;
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 15; x++) begin
        read_cell(4'(x), 4'(y), d);
        if (d != 2'b00) bad++;
      end
    end
    check_eq("clr_all_cells", bad, 0);

    // Reset in the middle of a commanded clear
    drive_cmd(2'b01, 4'd5, 4'd5, 2'b10);
    tick();
    drive_cmd(2'b10, 4'd0, 4'd0, 2'b00);
    tick();
    idle_cmd();
    dn = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) dn++;
    end
    reset = 1'b1;
    tick();
    check_eq("mid_rst_ready", cmd_ready, 0);
    check_eq("mid_rst_done", done, 0);
    reset = 1'b0;
    rd_x = 4'd5;
    rd_y = 4'd5;
    wait_ready(cyc, bad, bl);
    check_eq("mid_rst_cycles", cyc, 225);
    check_eq("mid_rst_no_done", dn + bad + int'(done), 0);
    check_eq("mid_rst_blank", bl, 0);
    read_cell(4'd5, 4'd5, d);
    check_eq("mid_rst_rd_5_5", d, 0);
    check_eq("mid_rst_snake", snake_count, 0);

    // Same-cycle read/write, then raster with one food cell
    drive_cmd(2'b01, 4'd7, 4'd7, 2'b01);
    read_cell(4'd7, 4'd7, d);
    check_eq("rw_same_cycle_old", d, 0);
    tick();
    idle_cmd();
    read_cell(4'd7, 4'd7, d);
    check_eq("rw_next_cycle_new", d, 1);
    check_eq("rw_food", food_count, 1);
    bad = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        read_cell(4'(x), 4'(y), d);
        exp_d = (x == 7 && y == 7) ? 2'b01 : 2'b00;
        if (d != exp_d) bad++;
      end
    end
    check_eq("raster_mismatches", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
